// File: rtl/gs_filter_pkg.sv
// gs_filter_pkg: mode encodings, kernel weights, pipeline latency and FSM state type
// shared by the 3x3 window filter.
package gs_filter_pkg;
    localparam logic [1:0] MODE_BYP       = 2'b00;
    localparam logic [1:0] MODE_GAUSS     = 2'b01;
    localparam logic [1:0] MODE_HORZ      = 2'b10;
    localparam logic [1:0] MODE_GAUSS_ALT = 2'b11;
    localparam logic [2:0] W_CORNER = 3'd1;
    localparam logic [2:0] W_EDGE   = 3'd2;
    localparam logic [2:0] W_CENTRE = 3'd4;
    localparam int LATENCY = 2;
    typedef enum logic {IDLE, ACTIVE} state_t;
endpackage

// File: rtl/gs_filter_win_if.sv
// gs_filter_win_if: pixel stream in/out bundle for the window filter; master drives pixels,
// slave (the filter) drives results.
interface gs_filter_win_if #(parameter int DATA_W = 8);
    logic [1:0]        mode;
    logic [DATA_W-1:0] din;
    logic              din_vld, din_sop, din_eop;
    logic [DATA_W-1:0] dout;
    logic              dout_vld, dout_sop, dout_eop, frame_err;
    modport master(output mode, din, din_vld, din_sop, din_eop,
                   input dout, dout_vld, dout_sop, dout_eop, frame_err);
    modport slave(input mode, din, din_vld, din_sop, din_eop,
                  output dout, dout_vld, dout_sop, dout_eop, frame_err);
endinterface

// File: rtl/gs_line_buf.sv
// gs_line_buf: enable-driven DATA_W x DEPTH delay line with one tap at the far end.
// Contents are deliberately not reset.
module gs_line_buf #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 640
) (
    input  logic              clk,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);
    logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
    always_comb mem_d = en ? {mem_q[DEPTH-2:0], d} : mem_q;
    always_ff @(posedge clk) mem_q <= mem_d;
    assign q = mem_q[DEPTH-1];
endmodule

// File: rtl/gs_filter_win.sv
// gs_filter_win: 3x3 window filter (bypass / gaussian / horizontal 1-2-1) with border masking
// and framing checks. Define GS_FILTER_ROUND_EN for round-half-up instead of truncation.
module gs_filter_win
    import gs_filter_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int BORDER_VAL = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    gs_filter_win_if.slave  bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int GW = DATA_W + 4;
    localparam int HW = DATA_W + 2;
`ifdef GS_FILTER_ROUND_EN
    localparam logic [GW-1:0] RND_G = GW'(8);
    localparam logic [HW-1:0] RND_H = HW'(2);
`else
    localparam logic [GW-1:0] RND_G = '0;
    localparam logic [HW-1:0] RND_H = '0;
`endif
    localparam logic [DATA_W-1:0] MAXV = '1;

    state_t                      state_q, state_d;
    logic [CW-1:0]               col_q, col_d, pos_c;
    logic [RW-1:0]               row_q, row_d, pos_r;
    logic                        acc, wrap, last_row, err;
    logic [DATA_W-1:0]           mid_tap, top_tap, res, dout_q, dout_d;
    logic [2:0][2:0][DATA_W-1:0] win_q, win_d;
    logic [1:0]                  mode_q, mode_d;
    logic                        s1_vld_q, s1_vld_d, s1_sop_q, s1_sop_d, s1_eop_q, s1_eop_d;
    logic                        s1_err_q, s1_err_d, s1_bord_q, s1_bord_d;
    logic                        vld_q, sop_q, eop_q, err_q, is_byp, is_gauss;
    logic [GW-1:0]               g_sum, g_res;
    logic [HW-1:0]               h_sum, h_res;

    gs_line_buf #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb_mid (.clk(clk), .en(acc), .d(bus.din), .q(mid_tap));
    gs_line_buf #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb_top (.clk(clk), .en(acc), .d(mid_tap), .q(top_tap));

    // A sop always restarts at (0,0), whether it arrives in IDLE or mid-frame.
    always_comb begin
        acc      = bus.din_vld & (bus.din_sop | (state_q == ACTIVE));
        pos_c    = bus.din_sop ? '0 : col_q;
        pos_r    = bus.din_sop ? '0 : row_q;
        wrap     = pos_c == CW'(IMG_W - 1);
        last_row = pos_r == RW'(IMG_H - 1);
        err      = acc & ((bus.din_sop & (state_q == ACTIVE)) | (bus.din_eop ^ (wrap & last_row)));
        state_d  = !acc ? state_q : bus.din_eop ? IDLE : ACTIVE;
        col_d    = !acc ? col_q : (bus.din_eop | wrap) ? '0 : pos_c + 1'b1;
        row_d    = !acc ? row_q : bus.din_eop ? '0 : !wrap ? pos_r : last_row ? '0 : pos_r + 1'b1;
        s1_vld_d  = acc;
        s1_sop_d  = acc & bus.din_sop;
        s1_eop_d  = acc & bus.din_eop;
        s1_err_d  = err;
        s1_bord_d = acc ? (pos_r < RW'(2)) | (pos_c < CW'(2)) : s1_bord_q;
        mode_d    = acc ? bus.mode : mode_q;
        win_d     = acc ? {bus.din, win_q[2][2], win_q[2][1],
                           mid_tap, win_q[1][2], win_q[1][1],
                           top_tap, win_q[0][2], win_q[0][1]} : win_q;
    end

    always_comb begin
        is_byp   = mode_q == MODE_BYP;
        is_gauss = (mode_q == MODE_GAUSS) | (mode_q == MODE_GAUSS_ALT);
        g_sum = GW'(W_CORNER) * (GW'(win_q[0][0]) + GW'(win_q[0][2]) + GW'(win_q[2][0]) + GW'(win_q[2][2]))
              + GW'(W_EDGE) * (GW'(win_q[0][1]) + GW'(win_q[1][0]) + GW'(win_q[1][2]) + GW'(win_q[2][1]))
              + GW'(W_CENTRE) * GW'(win_q[1][1]) + RND_G;
        h_sum = HW'(W_CORNER) * (HW'(win_q[1][0]) + HW'(win_q[1][2])) + HW'(W_EDGE) * HW'(win_q[1][1]) + RND_H;
        g_res = g_sum >> 4;
        h_res = h_sum >> 2;
        res = is_byp ? win_q[2][2] : s1_bord_q ? DATA_W'(BORDER_VAL) :
              is_gauss ? (g_res > GW'(MAXV) ? MAXV : g_res[DATA_W-1:0]) :
                         (h_res > HW'(MAXV) ? MAXV : h_res[DATA_W-1:0]);
        dout_d = s1_vld_q ? res : dout_q;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            win_q     <= '0;
            mode_q    <= '0;
            s1_vld_q  <= 1'b0;
            s1_sop_q  <= 1'b0;
            s1_eop_q  <= 1'b0;
            s1_err_q  <= 1'b0;
            s1_bord_q <= 1'b0;
            dout_q    <= '0;
            vld_q     <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            win_q     <= win_d;
            mode_q    <= mode_d;
            s1_vld_q  <= s1_vld_d;
            s1_sop_q  <= s1_sop_d;
            s1_eop_q  <= s1_eop_d;
            s1_err_q  <= s1_err_d;
            s1_bord_q <= s1_bord_d;
            dout_q    <= dout_d;
            vld_q     <= s1_vld_q;
            sop_q     <= s1_sop_q;
            eop_q     <= s1_eop_q;
            err_q     <= s1_err_q;
        end
    end

    assign bus.dout      = dout_q;
    assign bus.dout_vld  = vld_q;
    assign bus.dout_sop  = sop_q;
    assign bus.dout_eop  = eop_q;
    assign bus.frame_err = err_q;
endmodule

// File: tb/tb_gs_filter_win.sv
// tb_gs_filter_win: directed, table-driven bench for gs_filter_win at IMG_W=8, IMG_H=4.
module tb_gs_filter_win;
    typedef struct {int kind; int mode; int r; int c; int exp;} vec_t;
    typedef struct {int dout; bit sop; bit eop; bit err;} out_t;
    localparam int NV = 25;
`ifdef GS_FILTER_ROUND_EN
    localparam int RND3 = 1;
`else
    localparam int RND3 = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int checks = 0, errors = 0, cyc = 0, sop_cyc = 0, lat = -1, stray = 0;
    out_t q[$];
    vec_t vt[NV];

    gs_filter_win_if #(.DATA_W(8)) bus();
    gs_filter_win #(.DATA_W(8), .IMG_W(8), .IMG_H(4), .BORDER_VAL(0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus.dout_vld) q.push_back('{int'(bus.dout), bus.dout_sop, bus.dout_eop, bus.frame_err});
        if (bus.dout_vld && bus.dout_sop) lat <= cyc - sop_cyc;
        if (bus.din_vld && bus.din_sop) sop_cyc <= cyc;
        if (!bus.dout_vld && (bus.dout_sop || bus.dout_eop || bus.frame_err)) stray <= stray + 1;
    end

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic out_t qg(input int i);
        out_t o = '{-1, 1'b0, 1'b0, 1'b0};
        if (i < q.size()) o = q[i];
        return o;
    endfunction

    function automatic int pv(input int kind, input int r, input int c);
        case (kind)
            0: return 100;
            1: return (r == 2 && c == 2) ? 160 : 0;
            2: return (r == 2 && c == 2) ? 3 : 0;
            default: return c * 10;
        endcase
    endfunction

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic px(input int v, input bit s, input bit e, input int m);
        bus.din = 8'(v);
        bus.mode = 2'(m);
        bus.din_vld = 1'b1;
        bus.din_sop = s;
        bus.din_eop = e;
        @(posedge clk);
        #1;
        bus.din_vld = 1'b0;
        bus.din_sop = 1'b0;
        bus.din_eop = 1'b0;
    endtask

    task automatic send(input int kind, input int m, input bit gaps, input int n, input bit eop_last);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                if (i % 2 == 1) idle();
                repeat ($urandom_range(0, 2)) idle();
            end
            px(pv(kind, i / 8, i % 8), i == 0, eop_last && i == n - 1, m);
        end
    endtask

    task automatic check_frame(input string nm, input int kind, input int m, input int base);
        for (int i = 0; i < NV; i++)
            if (vt[i].kind == kind && vt[i].mode == m)
                chk($sformatf("%s_r%0dc%0d", nm, vt[i].r, vt[i].c), qg(base + vt[i].r * 8 + vt[i].c).dout, vt[i].exp);
        if (kind == 0 && m != 0 && m != 2)
            for (int i = 0; i < 32; i++)
                chk($sformatf("%s_px%0d", nm, i), qg(base + i).dout, (i / 8 < 2 || i % 8 < 2) ? 0 : 100);
    endtask

    task automatic run_frame(input string nm, input int kind, input int m, input bit gaps);
        int ns = 0, ne = 0, nerr = 0;
        q.delete();
        send(kind, m, gaps, 32, 1'b1);
        repeat (4) idle();
        foreach (q[i]) begin
            ns += int'(q[i].sop);
            ne += int'(q[i].eop);
            nerr += int'(q[i].err);
        end
        chk({nm, "_count"}, q.size(), 32);
        chk({nm, "_sop_first"}, int'(qg(0).sop), 1);
        chk({nm, "_eop_last"}, int'(qg(31).eop), 1);
        chk({nm, "_sop_total"}, ns, 1);
        chk({nm, "_eop_total"}, ne, 1);
        chk({nm, "_err_total"}, nerr, 0);
        chk({nm, "_latency"}, lat, 2);
        check_frame(nm, kind, m, 0);
    endtask

    initial begin
        int nerr;
        vt = '{'{0,1,0,0,0}, '{0,1,1,6,0}, '{0,1,3,1,0}, '{0,1,2,2,100}, '{0,1,3,7,100},
               '{1,1,3,3,40}, '{1,1,3,2,20}, '{1,1,3,4,20}, '{1,1,2,3,20}, '{1,1,2,2,10},
               '{1,1,3,5,0}, '{2,1,3,3,RND3}, '{2,1,2,3,0},
               '{3,0,0,0,0}, '{3,0,0,1,10}, '{3,0,1,3,30}, '{3,0,3,7,70},
               '{3,2,2,5,40}, '{3,2,3,7,60}, '{3,2,1,4,0}, '{3,2,2,1,0},
               '{1,2,3,3,80}, '{1,2,3,4,40}, '{1,2,2,3,0}, '{0,3,3,3,100}};
        bus.mode = 2'd0;
        bus.din = 8'd0;
        bus.din_vld = 1'b0;
        bus.din_sop = 1'b0;
        bus.din_eop = 1'b0;
        repeat (3) idle();
        chk("rst_dout", int'(bus.dout), 0);
        chk("rst_vld", int'(bus.dout_vld), 0);
        chk("rst_sop", int'(bus.dout_sop), 0);
        chk("rst_eop", int'(bus.dout_eop), 0);
        chk("rst_err", int'(bus.frame_err), 0);
        rst_n = 1'b0;
        repeat (2) idle();

        run_frame("const_g", 0, 1, 1'b0);
        run_frame("imp160", 1, 1, 1'b0);
        run_frame("imp3", 2, 1, 1'b0);
        run_frame("ramp_byp", 3, 0, 1'b0);
        run_frame("ramp_h", 3, 2, 1'b0);
        run_frame("imp_h", 1, 2, 1'b0);
        run_frame("const_m3", 0, 3, 1'b0);
        run_frame("const_gap", 0, 1, 1'b1);

        q.delete();
        send(0, 1, 1'b0, 21, 1'b1);
        repeat (3) px(77, 1'b0, 1'b0, 1);
        repeat (4) idle();
        nerr = 0;
        foreach (q[i]) nerr += int'(q[i].err);
        chk("early_eop_count", q.size(), 21);
        chk("early_eop_err", int'(qg(20).err), 1);
        chk("early_eop_eop", int'(qg(20).eop), 1);
        chk("early_eop_dout", qg(20).dout, 100);
        chk("early_eop_err_total", nerr, 1);
        run_frame("after_eop", 0, 1, 1'b0);

        q.delete();
        send(0, 1, 1'b0, 5, 1'b0);
        send(0, 1, 1'b0, 32, 1'b1);
        repeat (4) idle();
        nerr = 0;
        foreach (q[i]) nerr += int'(q[i].err);
        chk("restart_count", q.size(), 37);
        chk("restart_err", int'(qg(5).err), 1);
        chk("restart_sop", int'(qg(5).sop), 1);
        chk("restart_eop", int'(qg(36).eop), 1);
        chk("restart_err_total", nerr, 1);
        check_frame("restart", 0, 1, 5);

        q.delete();
        px(50, 1'b1, 1'b1, 1);
        px(60, 1'b0, 1'b0, 1);
        repeat (4) idle();
        chk("sopeop_count", q.size(), 1);
        chk("sopeop_sop", int'(qg(0).sop), 1);
        chk("sopeop_eop", int'(qg(0).eop), 1);
        chk("sopeop_err", int'(qg(0).err), 1);
        chk("sopeop_dout", qg(0).dout, 0);

        q.delete();
        send(3, 0, 1'b0, 15, 1'b0);
        chk("pre_rst_vld", int'(bus.dout_vld), 1);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_vld", int'(bus.dout_vld), 0);
        chk("mid_rst_dout", int'(bus.dout), 0);
        repeat (2) idle();
        rst_n = 1'b0;
        q.delete();
        repeat (3) px(90, 1'b0, 1'b0, 1);
        repeat (4) idle();
        chk("post_rst_ignored", q.size(), 0);
        run_frame("post_rst", 0, 1, 1'b0);

        chk("stray_side_bits", stray, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
